// File: rtl/dice_pkg.sv
// rtl/dice_pkg.sv - shared types, face constants and face increment for the dice roller
package dice_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SPIN = 2'd1,
    SLOW = 2'd2
  } roll_state_t;

  localparam logic [3:0] DIE_MIN    = 4'd1;
  localparam logic [3:0] DIE_MAX    = 4'd6;
  localparam logic [3:0] FACE_BLANK = 4'd0;

  // Out-of-range inputs (including blank) land on DIE_MIN so a face is always 1..6
  function automatic logic [3:0] next_face(input logic [3:0] f);
    if (f >= DIE_MAX || f < DIE_MIN) begin
      return DIE_MIN;
    end
    return f + 4'd1;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - two-flop synchronizer with registered previous level for rise detection
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= d;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~prev;

endmodule

// File: rtl/dice_roller.sv
// rtl/dice_roller.sv - push-button die: spin while held, decelerating settle, then hold the face
module dice_roller
  import dice_pkg::*;
#(
  parameter int TICK_DIV   = 4,
  parameter int SLOW_STEPS = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       roll_btn,
  output logic [3:0] value,
  output logic       rolling,
  output logic       done,
  output logic [7:0] roll_count
);

  localparam int CNT_MAX = TICK_DIV * (SLOW_STEPS + 1);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int K_W     = $clog2(SLOW_STEPS + 1);

  localparam logic [CNT_W-1:0] TICK_UNIT = CNT_W'(TICK_DIV);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [K_W-1:0]   STEP_LAST = K_W'(SLOW_STEPS - 1);

  logic roll_s;
  logic press;

  roll_state_t      state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [K_W-1:0]   step, step_d;
  logic [3:0]       seed;
  logic [3:0]       value_d;
  logic             rolling_d;
  logic             done_d;
  logic [7:0]       count_d;

  logic [CNT_W-1:0] slow_limit;
  logic             tick_wrap;
  logic             slow_wrap;
  logic             last_step;

  sync_edge u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (roll_btn),
    .level (roll_s),
    .rise  (press)
  );

  // Step k of the settle phase lasts TICK_DIV*(k+2) cycles, so the die visibly slows down
  assign slow_limit = TICK_UNIT * (CNT_W'(step) + CNT_W'(2)) - CNT_W'(1);
  assign tick_wrap  = (cnt == TICK_LAST);
  assign slow_wrap  = (cnt == slow_limit);
  assign last_step  = (step == STEP_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      step       <= '0;
      seed       <= DIE_MIN;
      value      <= FACE_BLANK;
      rolling    <= 1'b0;
      done       <= 1'b0;
      roll_count <= 8'd0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      step       <= step_d;
      seed       <= next_face(seed);
      value      <= value_d;
      rolling    <= rolling_d;
      done       <= done_d;
      roll_count <= count_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (press) state_d = SPIN;
      end
      SPIN: begin
        if (!roll_s) state_d = SLOW;
      end
      SLOW: begin
        if (press) begin
          state_d = SPIN;
        end else if (slow_wrap && last_step) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt;
    step_d  = step;
    value_d = value;
    done_d  = 1'b0;
    count_d = roll_count;
    unique case (state)
      IDLE: begin
        if (press) begin
          value_d = seed;
          cnt_d   = '0;
        end
      end
      SPIN: begin
        // Release wins over a coincident tick so the settle phase starts cleanly
        if (!roll_s) begin
          cnt_d  = '0;
          step_d = '0;
        end else if (tick_wrap) begin
          cnt_d   = '0;
          value_d = next_face(value);
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      SLOW: begin
        if (press) begin
          cnt_d = '0;
        end else if (slow_wrap) begin
          cnt_d = '0;
          if (last_step) begin
            value_d = seed;
            done_d  = 1'b1;
            if (roll_count != 8'hFF) count_d = roll_count + 8'd1;
          end else begin
            value_d = next_face(value);
            step_d  = step + K_W'(1);
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: begin
        cnt_d  = '0;
        step_d = '0;
      end
    endcase
    rolling_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_dice_roller.sv
// tb/tb_dice_roller.sv - randomized scoreboard bench for dice_roller against an event-level model
module tb_dice_roller;

  localparam int TD = 4;
  localparam int S  = 5;

  typedef struct {
    int t;
    int v;
    int r;
    int d;
    int c;
  } ev_t;

  logic       clk;
  logic       rst_n;
  logic       roll_btn;
  logic [3:0] value;
  logic       rolling;
  logic       done;
  logic [7:0] roll_count;

  int  total = 0;
  int  bad   = 0;
  int  cyc;
  ev_t exp_q[$];
  ev_t ev;
  int  mv;
  int  mc;
  logic [3:0] pv;
  logic       pr;

  dice_roller #(.TICK_DIV(TD), .SLOW_STEPS(S)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .roll_btn   (roll_btn),
    .value      (value),
    .rolling    (rolling),
    .done       (done),
    .roll_count (roll_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since the last reset release; the free-running seed is a pure function of it
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic int seed_at(input int t);
    return ((t - 1) % 6) + 1;
  endfunction

  task automatic check(input string name, input int act, input int want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d (cyc %0d)", name, act, want, cyc);
    end
  endtask

  task automatic push(input int t, input int v, input int r, input int d, input int c);
    ev_t e;
    e.t = t; e.v = v; e.r = r; e.d = d; e.c = c;
    exp_q.push_back(e);
  endtask

  task automatic plan_spin(input int p, input int r, input bit from_idle);
    if (from_idle) begin
      mv = seed_at(p);
      push(p, mv, 1, 0, mc);
    end
    for (int t = p + TD; t < r; t += TD) begin
      mv = (mv % 6) + 1;
      push(t, mv, 1, 0, mc);
    end
  endtask

  // abort_t > 0: a re-press takes effect on that edge, dropping the remaining steps
  task automatic plan_slow(input int r, input int abort_t, output int dt);
    int t;
    t  = r;
    dt = -1;
    for (int k = 0; k < S; k++) begin
      t += TD * (k + 2);
      if (abort_t > 0 && t >= abort_t) return;
      if (k < S - 1) begin
        mv = (mv % 6) + 1;
        push(t, mv, 1, 0, mc);
      end else begin
        mv = seed_at(t);
        mc = (mc < 255) ? mc + 1 : 255;
        push(t, mv, 0, 1, mc);
        dt = t;
      end
    end
  endtask

  task automatic wait_until(input int t);
    for (int i = 0; i < 5000 && cyc < t; i++) @(negedge clk);
    if (cyc < t) begin
      total++;
      bad++;
      $display("FAIL wait_timeout got=%0d want=%0d", cyc, t);
    end
  endtask

  task automatic roll(input int hold, output int dt);
    int c0;
    c0 = cyc;
    plan_spin(c0 + 3, c0 + hold + 3, 1'b1);
    plan_slow(c0 + hold + 3, 0, dt);
    roll_btn = 1'b1;
    repeat (hold) @(negedge clk);
    roll_btn = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 4'd0;
      pr = 1'b0;
    end else if (value !== pv || rolling !== pr || done !== 1'b0) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event got t=%0d v=%0d r=%0d d=%0d c=%0d want none",
                 cyc, value, rolling, done, roll_count);
      end else begin
        ev = exp_q.pop_front();
        if (ev.t != cyc || ev.v != int'(value) || ev.r != int'(rolling) ||
            ev.d != int'(done) || ev.c != int'(roll_count)) begin
          bad++;
          $display("FAIL event got t=%0d v=%0d r=%0d d=%0d c=%0d want t=%0d v=%0d r=%0d d=%0d c=%0d",
                   cyc, value, rolling, done, roll_count, ev.t, ev.v, ev.r, ev.d, ev.c);
        end
      end
      pv = value;
      pr = rolling;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    int dt, c0, r1, p2, r2;
    rst_n    = 1'b0;
    roll_btn = 1'b0;
    mv = 0;
    mc = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_value", int'(value), 0);
    check("reset_rolling", int'(rolling), 0);
    check("reset_done", int'(done), 0);
    check("reset_count", int'(roll_count), 0);
    repeat (10) @(negedge clk);
    check("idle_hold_value", int'(value), 0);
    check("idle_hold_rolling", int'(rolling), 0);

    // Long spin, then natural settle
    roll(60, dt);
    wait_until(dt);
    check("settle_done", int'(done), 1);
    check("settle_value", int'(value), seed_at(dt));
    check("settle_count", int'(roll_count), 1);
    @(negedge clk);
    check("done_one_cycle", int'(done), 0);
    check("idle_after_done", int'(rolling), 0);

    // Re-press 30 cycles into SLOW
    repeat (3) @(negedge clk);
    c0 = cyc;
    r1 = c0 + 10 + 3;
    p2 = r1 + 30;
    r2 = p2 + 12;
    plan_spin(c0 + 3, r1, 1'b1);
    plan_slow(r1, p2, dt);
    plan_spin(p2, r2, 1'b0);
    plan_slow(r2, 0, dt);
    roll_btn = 1'b1;
    repeat (10) @(negedge clk);
    roll_btn = 1'b0;
    wait_until(p2 - 3);
    roll_btn = 1'b1;
    repeat (3) @(negedge clk);
    check("repress_rolling", int'(rolling), 1);
    check("repress_count", int'(roll_count), 1);
    repeat (9) @(negedge clk);
    roll_btn = 1'b0;
    wait_until(dt);
    check("repress_done", int'(done), 1);
    check("repress_final_count", int'(roll_count), 2);
    check("repress_slow_len", dt - r2, 80);

    // Reset in the middle of a spin
    @(negedge clk);
    c0 = cyc;
    plan_spin(c0 + 3, c0 + 21, 1'b1);
    roll_btn = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    rst_n    = 1'b0;
    roll_btn = 1'b0;
    #1;
    check("midreset_value", int'(value), 0);
    check("midreset_rolling", int'(rolling), 0);
    check("midreset_done", int'(done), 0);
    check("midreset_count", int'(roll_count), 0);
    check("midreset_pending", exp_q.size(), 0);
    exp_q.delete();
    mv = 0;
    mc = 0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("postreset_value", int'(value), 0);
    check("postreset_rolling", int'(rolling), 0);

    // Back-to-back rolls to saturate the counter
    for (int n = 1; n <= 257; n++) begin
      roll($urandom_range(6, 1), dt);
      wait_until(dt);
      if (n >= 255) check("sat_count", int'(roll_count), (n < 255) ? n : 255);
      repeat ($urandom_range(2, 0)) @(negedge clk);
    end

    repeat (20) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
